trng_scheduler: RTL and testbench

- Shares the single TRNG word generator between NUM_REQ on-chip consumers, e.g. key generation, nonce and IV/mask units.
- Sequences the TRNG request/ready handshake, arbitrates requesters round-robin and health-checks each 32-bit word before delivery.
- Detects a stuck or missing TRNG (timeout, repeated failures) and parks in a sticky fault state until cleared.

---
 rtl/trng_sched_pkg.sv | 29 ++
 rtl/trng_scheduler_rr_arbiter.sv | 38 +++
 rtl/trng_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_trng_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_sched_pkg.sv
// Shared types and constants for the TRNG scheduler.
// Holds the FSM state encoding and the health-test helper.
package trng_sched_pkg;

    localparam int TRNG_W = 32;

    localparam logic [TRNG_W-1:0] WORD_ZERO = '0;
    localparam logic [TRNG_W-1:0] WORD_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_DELIVER,
        ST_RELEASE,
        ST_FAULT
    } state_e;

    // A word is rejected if it is all-zero, all-one, or a repeat
    // of the last delivered word.
    function automatic logic word_bad(
        input logic [TRNG_W-1:0] w,
        input logic              lv,
        input logic [TRNG_W-1:0] lw
    );
        return (w == WORD_ZERO) || (w == WORD_ONES) || (lv && (w == lw));
    endfunction

endpackage

// File: rtl/trng_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// Searches upward from ptr_i with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_o
);

    logic             found;
    logic [IDX_W-1:0] idx;
    int               sum;

    // First set request at or after the pointer, wrapping round.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        sum     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr_i) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!found && req_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/trng_scheduler.sv
// Shares one TRNG between several consumers with round-robin grants,
// per-word health checks and sticky timeout / health fault reporting.
module trng_scheduler
    import trng_sched_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int TIMEOUT    = 64,
    parameter int FAIL_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] rnd_valid,
    output logic [TRNG_W-1:0] rnd_data,
    output logic              busy,
    output logic              health_fail,
    output logic              timeout_err,
    input  logic              fault_clr,
    output logic              trng_request,
    input  logic              trng_ready,
    input  logic [TRNG_W-1:0] trng_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int FC_W  = $clog2(FAIL_LIMIT + 1);

    state_e              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    grant_q;
    logic [FC_W-1:0]     fail_cnt_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [TRNG_W-1:0]   word_q;
    logic [TRNG_W-1:0]   last_word_q;
    logic                last_valid_q;
    logic                retry_q;
    logic [NUM_REQ-1:0]  rnd_valid_q;
    logic [TRNG_W-1:0]   rnd_data_q;
    logic                busy_q;
    logic                health_fail_q;
    logic                timeout_err_q;
    logic                trng_request_q;

    logic [IDX_W-1:0]    arb_grant;
    logic                arb_any;
    logic [IDX_W-1:0]    ptr_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    // Pointer moves one past the requester just served.
    always_comb begin
        ptr_d = grant_q + 1'b1;
        if (grant_q == IDX_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end
    end

    // Main scheduler FSM; every output is a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            fail_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            word_q         <= '0;
            last_word_q    <= '0;
            last_valid_q   <= 1'b0;
            retry_q        <= 1'b0;
            rnd_valid_q    <= '0;
            rnd_data_q     <= '0;
            busy_q         <= 1'b0;
            health_fail_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
            trng_request_q <= 1'b0;
        end else begin
            rnd_valid_q <= '0;
            rnd_data_q  <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    // Never raise request while the TRNG still shows ready.
                    if (arb_any && !trng_ready) begin
                        grant_q        <= arb_grant;
                        tmo_cnt_q      <= '0;
                        busy_q         <= 1'b1;
                        trng_request_q <= 1'b1;
                        state_q        <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!req[grant_q]) begin
                        tmo_cnt_q      <= '0;
                        trng_request_q <= 1'b0;
                        state_q        <= ST_RELEASE;
                    end else if (trng_ready) begin
                        word_q         <= trng_data;
                        tmo_cnt_q      <= '0;
                        trng_request_q <= 1'b0;
                        state_q        <= ST_CHECK;
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        timeout_err_q  <= 1'b1;
                        trng_request_q <= 1'b0;
                        state_q        <= ST_FAULT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (word_bad(word_q, last_valid_q, last_word_q)) begin
                        word_q <= '0;
                        if (fail_cnt_q == FC_W'(FAIL_LIMIT - 1)) begin
                            health_fail_q <= 1'b1;
                            state_q       <= ST_FAULT;
                        end else begin
                            fail_cnt_q <= fail_cnt_q + 1'b1;
                            retry_q    <= 1'b1;
                            state_q    <= ST_RELEASE;
                        end
                    end else begin
                        fail_cnt_q  <= '0;
                        rnd_valid_q <= NUM_REQ'(1) << grant_q;
                        rnd_data_q  <= word_q;
                        state_q     <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    last_word_q  <= word_q;
                    last_valid_q <= 1'b1;
                    rr_ptr_q     <= ptr_d;
                    word_q       <= '0;
                    state_q      <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Wait for the TRNG collector to drop ready.
                    if (!trng_ready) begin
                        retry_q <= 1'b0;
                        if (retry_q && req[grant_q]) begin
                            tmo_cnt_q      <= '0;
                            trng_request_q <= 1'b1;
                            state_q        <= ST_COLLECT;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        health_fail_q <= 1'b0;
                        timeout_err_q <= 1'b0;
                        fail_cnt_q    <= '0;
                        tmo_cnt_q     <= '0;
                        state_q       <= ST_RELEASE;
                    end
                end
                default: begin
                    busy_q         <= 1'b0;
                    trng_request_q <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    assign rnd_valid    = rnd_valid_q;
    assign rnd_data     = rnd_data_q;
    assign busy         = busy_q;
    assign health_fail  = health_fail_q;
    assign timeout_err  = timeout_err_q;
    assign trng_request = trng_request_q;

endmodule

// File: tb/tb_trng_scheduler.sv
// Directed bench for trng_scheduler with a simple TRNG model
// that raises ready 33 cycles after request goes high.
module tb_trng_scheduler;
    import trng_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  rnd_valid;
    logic [31:0] rnd_data;
    logic        busy;
    logic        health_fail;
    logic        timeout_err;
    logic        fault_clr = 1'b0;
    logic        trng_request;
    logic        trng_ready = 1'b0;
    logic [31:0] trng_data;

    logic [31:0] wtab [64];
    logic [5:0]  rd = '0;
    int          cnt = 0;
    logic        stall = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    trng_scheduler #(
        .NUM_REQ    (3),
        .TIMEOUT    (64),
        .FAIL_LIMIT (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .rnd_valid    (rnd_valid),
        .rnd_data     (rnd_data),
        .busy         (busy),
        .health_fail  (health_fail),
        .timeout_err  (timeout_err),
        .fault_clr    (fault_clr),
        .trng_request (trng_request),
        .trng_ready   (trng_ready),
        .trng_data    (trng_data)
    );

    always #5 clk = ~clk;

    // TRNG model: next word is consumed as ready falls.
    always @(posedge clk) begin
        if (!trng_request) begin
            if (trng_ready) rd <= rd + 6'd1;
            trng_ready <= 1'b0;
            cnt        <= 0;
        end else if (cnt == 32) begin
            if (!stall) trng_ready <= 1'b1;
        end else begin
            cnt <= cnt + 1;
        end
    end

    assign trng_data = wtab[rd];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int k, input logic [31:0] w);
        wtab[rd + 6'(k)] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_pulse(input int max, output logic [2:0] v,
                              output logic [31:0] d);
        int n;
        n = 0;
        v = '0;
        d = '0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (rnd_valid != 3'b000) begin
                v = rnd_valid;
                d = rnd_data;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic watch(input int cyc, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (rnd_valid != 3'b000) seen = 1'b1;
        end
    endtask

    initial begin
        logic [2:0]  v;
        logic [31:0] d;
        logic        seen;
        int          n;

        for (int i = 0; i < 64; i++) wtab[i] = 32'hC0DE_0000 + i;

        // Reset state
        do_reset();
        check("rst_valid", rnd_valid, 0);
        check("rst_data", rnd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_hfail", health_fail, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_treq", trng_request, 0);
        check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        check("rst_ptr", dut.rr_ptr_q, 0);

        // Single requester, latency from grant
        load(0, 32'hA5A5_1234);
        req = 3'b001;
        @(negedge clk);
        check("s_busy", busy, 1);
        n = 0;
        while (n < 100 && rnd_valid == 3'b000) begin
            @(negedge clk);
            n++;
        end
        check("s_lat", n, 35);
        check("s_vld", rnd_valid, 3'b001);
        check("s_dat", rnd_data, 32'hA5A5_1234);
        check("s_treq_lo", trng_request, 0);
        req = 3'b000;
        @(negedge clk);
        check("s_pulse1", rnd_valid, 0);
        check("s_dat0", rnd_data, 0);
        check("s_word_clr", dut.word_q, 0);
        wait_idle("s_idle", 20);

        // Round-robin fairness
        do_reset();
        load(0, 32'h1111_0001);
        load(1, 32'h2222_0002);
        load(2, 32'h3333_0003);
        load(3, 32'h4444_0004);
        req = 3'b111;
        wait_pulse(200, v, d);
        check("rr0_v", v, 3'b001);
        check("rr0_d", d, 32'h1111_0001);
        wait_pulse(200, v, d);
        check("rr1_v", v, 3'b010);
        check("rr1_d", d, 32'h2222_0002);
        req = 3'b110;
        wait_pulse(200, v, d);
        check("rr2_v", v, 3'b100);
        check("rr2_d", d, 32'h3333_0003);
        wait_pulse(200, v, d);
        check("rr3_v", v, 3'b010);
        check("rr3_d", d, 32'h4444_0004);
        req = 3'b000;
        wait_idle("rr_idle", 20);

        // Health rejection and retry (ptr=2, grant 0)
        load(0, 32'h0000_0000);
        load(1, 32'hFFFF_FFFF);
        load(2, 32'h1357_9BDF);
        req = 3'b001;
        wait_pulse(300, v, d);
        check("h_v", v, 3'b001);
        check("h_d", d, 32'h1357_9BDF);
        check("h_fcnt", dut.fail_cnt_q, 0);
        req = 3'b000;
        wait_idle("h_idle", 20);

        // Repeat of last delivered word is rejected
        load(0, 32'h1357_9BDF);
        load(1, 32'h2468_ACE0);
        req = 3'b001;
        wait_pulse(300, v, d);
        check("rep_v", v, 3'b001);
        check("rep_d", d, 32'h2468_ACE0);
        req = 3'b000;
        wait_idle("rep_idle", 20);

        // Three bad words in a row -> health fault
        load(0, 32'h0000_0000);
        load(1, 32'hFFFF_FFFF);
        load(2, 32'h2468_ACE0);
        req = 3'b001;
        seen = 1'b0;
        n = 0;
        while (n < 300 && !health_fail) begin
            @(negedge clk);
            n++;
            if (rnd_valid != 3'b000) seen = 1'b1;
        end
        check("hf_flag", health_fail, 1);
        check("hf_novld", seen, 0);
        check("hf_state", 64'(dut.state_q), 64'(ST_FAULT));
        check("hf_treq", trng_request, 0);
        watch(4, seen);
        check("hf_park", 64'(dut.state_q), 64'(ST_FAULT));
        check("hf_busy", busy, 1);
        req = 3'b000;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("hf_clr", health_fail, 0);
        check("hf_fcnt", dut.fail_cnt_q, 0);
        wait_idle("hf_idle", 20);

        // Timeout with ready stuck low (ptr=1, grant 1)
        stall = 1'b1;
        req = 3'b010;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (timeout_err) break;
            if (trng_request) n++;
        end
        check("to_flag", timeout_err, 1);
        check("to_cycles", n, 64);
        check("to_treq", trng_request, 0);
        req = 3'b000;
        stall = 1'b0;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("to_clr", timeout_err, 0);
        wait_idle("to_idle", 20);
        load(0, 32'h5A5A_0F0F);
        req = 3'b010;
        wait_pulse(200, v, d);
        check("to_serve_v", v, 3'b010);
        check("to_serve_d", d, 32'h5A5A_0F0F);
        req = 3'b000;
        wait_idle("to_idle2", 20);

        // Cancel mid-COLLECT (ptr=2, grant 1)
        req = 3'b010;
        repeat (11) @(negedge clk);
        check("c_treq_hi", trng_request, 1);
        req = 3'b000;
        @(negedge clk);
        check("c_treq_lo", trng_request, 0);
        watch(6, seen);
        check("c_novld", seen, 0);
        check("c_ptr", dut.rr_ptr_q, 2);
        check("c_idle", busy, 0);

        // Cancel in the same cycle ready arrives (grant 0)
        load(0, 32'h7777_1234);
        req = 3'b001;
        n = 0;
        while (n < 100 && !trng_ready) begin
            @(negedge clk);
            n++;
        end
        check("cr_ready", trng_ready, 1);
        req = 3'b000;
        watch(8, seen);
        check("cr_novld", seen, 0);
        check("cr_ptr", dut.rr_ptr_q, 2);
        check("cr_idle", busy, 0);

        // Reset in the middle of COLLECT
        load(0, 32'h3C3C_5A5A);
        req = 3'b001;
        repeat (6) @(negedge clk);
        check("rm_treq", trng_request, 1);
        req = 3'b000;
        do_reset();
        check("rm_treq0", trng_request, 0);
        check("rm_busy", busy, 0);
        check("rm_state", 64'(dut.state_q), 64'(ST_IDLE));
        check("rm_ptr", dut.rr_ptr_q, 0);

        // Reset clears a sticky flag
        stall = 1'b1;
        req = 3'b001;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (timeout_err) break;
        end
        check("rs_tmo_set", timeout_err, 1);
        req = 3'b000;
        stall = 1'b0;
        do_reset();
        check("rs_tmo_clr", timeout_err, 0);
        check("rs_state", 64'(dut.state_q), 64'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
